// File: rtl/tlb_refill_walker_pkg.sv
// Shared MMU definitions for the TLB refill walker: walk states, field widths
// and the VPN index helpers for the two-level page table.
package mmu_pkg;

    localparam int unsigned PTE_W     = 24;
    localparam int unsigned VPN_W     = 20;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned PTE_V_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PDE,
        S_PTE,
        S_WRITE,
        S_FAULT,
        S_DRAIN
    } walk_state_e;

    // L1_IDX = vpn[19:10], L2_IDX = vpn[9:0]
    function automatic logic [9:0] l1_idx(input logic [VPN_W-1:0] v);
        return v[19:10];
    endfunction

    function automatic logic [9:0] l2_idx(input logic [VPN_W-1:0] v);
        return v[9:0];
    endfunction

endpackage

// File: rtl/tlb_refill_walker_if.sv
// Page-table read port between the refill walker (master) and memory (slave).
interface tlb_refill_walker_if;
    import mmu_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker feeding the TLB write port: on a miss it reads
// the PDE then the PTE, and either strobes tlbwr with the PTE or pulses page_fault.
module tlb_refill_walker
    import mmu_pkg::*;
#(
    parameter int unsigned PDE_SHIFT = 12
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 lookup,
    input  logic                 tlb_hit,
    input  logic [VPN_W-1:0]     vpn,
    input  logic [ADDR_W-1:0]    ptbr,
    input  logic                 kill,
    tlb_refill_walker_if.master  mem,
    output logic [PTE_W-1:0]     pte_in,
    output logic                 tlbwr,
    output logic                 stall,
    output logic                 page_fault,
    output logic [VPN_W-1:0]     bad_vpn
);

    walk_state_e       state_q, state_d;
    logic [VPN_W-1:0]  vpn_q, vpn_d;
    logic [ADDR_W-1:0] l2base_q, l2base_d;
    logic [PTE_W-1:0]  pte_q, pte_d;
    logic [VPN_W-1:0]  bad_vpn_q, bad_vpn_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;

    logic              miss;
    logic [ADDR_W-1:0] pde_addr;
    logic [ADDR_W-1:0] pte_addr;
    logic [ADDR_W-1:0] l2base_rd;
    logic              mem_req_c;
    logic [ADDR_W-1:0] mem_addr_c;

    assign miss      = lookup & ~tlb_hit & ~kill;
    assign pde_addr  = ptbr + {20'b0, l1_idx(vpn_q), 2'b00};
    assign pte_addr  = l2base_q + {20'b0, l2_idx(vpn_q), 2'b00};
    assign l2base_rd = {12'b0, mem.mem_rdata[31:12]} << PDE_SHIFT;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            vpn_q        <= '0;
            l2base_q     <= '0;
            pte_q        <= '0;
            bad_vpn_q    <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            vpn_q        <= vpn_d;
            l2base_q     <= l2base_d;
            pte_q        <= pte_d;
            bad_vpn_q    <= bad_vpn_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        vpn_d        = vpn_q;
        l2base_d     = l2base_q;
        pte_d        = pte_q;
        bad_vpn_d    = bad_vpn_q;
        drain_addr_d = drain_addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    vpn_d   = vpn;
                    state_d = S_PDE;
                end
            end
            S_PDE: begin
                // A kill with an outstanding request must still see its handshake.
                if (kill) begin
                    drain_addr_d = pde_addr;
                    state_d      = mem.mem_ready ? S_IDLE : S_DRAIN;
                end else if (mem.mem_ready) begin
                    if (!mem.mem_rdata[PTE_V_BIT]) begin
                        state_d = S_FAULT;
                    end else begin
                        l2base_d = l2base_rd;
                        state_d  = S_PTE;
                    end
                end
            end
            S_PTE: begin
                if (kill) begin
                    drain_addr_d = pte_addr;
                    state_d      = mem.mem_ready ? S_IDLE : S_DRAIN;
                end else if (mem.mem_ready) begin
                    if (!mem.mem_rdata[PTE_V_BIT]) begin
                        state_d = S_FAULT;
                    end else begin
                        pte_d   = mem.mem_rdata[PTE_W-1:0];
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_FAULT: begin
                bad_vpn_d = vpn_q;
                state_d   = S_IDLE;
            end
            S_DRAIN: begin
                if (mem.mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_c  = 1'b0;
        mem_addr_c = '0;
        tlbwr      = 1'b0;
        pte_in     = '0;
        page_fault = 1'b0;
        bad_vpn    = bad_vpn_q;
        unique case (state_q)
            S_PDE: begin
                mem_req_c  = 1'b1;
                mem_addr_c = pde_addr;
            end
            S_PTE: begin
                mem_req_c  = 1'b1;
                mem_addr_c = pte_addr;
            end
            S_DRAIN: begin
                mem_req_c  = 1'b1;
                mem_addr_c = drain_addr_q;
            end
            S_WRITE: begin
                tlbwr  = 1'b1;
                pte_in = pte_q;
            end
            S_FAULT: begin
                page_fault = 1'b1;
                bad_vpn    = vpn_q;
            end
            default: ;
        endcase
    end

    assign mem.mem_req  = mem_req_c;
    assign mem.mem_addr = mem_addr_c;
    assign stall        = (state_q != S_IDLE) | miss;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Self-checking bench for tlb_refill_walker: directed cycle tables plus a
// randomized run against a per-walk timeline model.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        clr;
    logic        lookup, tlb_hit, kill;
    logic [19:0] vpn;
    logic [31:0] ptbr;
    logic [23:0] pte_in;
    logic        tlbwr, stall, page_fault;
    logic [19:0] bad_vpn;

    tlb_refill_walker_if mif ();

    tlb_refill_walker #(.PDE_SHIFT(12)) dut (
        .clk        (clk),
        .clr        (clr),
        .lookup     (lookup),
        .tlb_hit    (tlb_hit),
        .vpn        (vpn),
        .ptbr       (ptbr),
        .kill       (kill),
        .mem        (mif),
        .pte_in     (pte_in),
        .tlbwr      (tlbwr),
        .stall      (stall),
        .page_fault (page_fault),
        .bad_vpn    (bad_vpn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lk, hit, kl, rdy;
        logic [19:0] vp;
        logic [31:0] rd, pb;
        logic        st, rq;
        logic [31:0] ad;
        logic        wr;
        logic [23:0] pt;
        logic        ft, cb;
        logic [19:0] eb;
    } vec_t;

    typedef struct {
        logic        rdy;
        logic [31:0] rd, ad;
        logic        rq, wr, ft;
        logic [23:0] pt;
        logic [19:0] fv;
    } step_t;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] cur_ptbr;
    vec_t        tbl[$];
    step_t       script[$];

    localparam logic [31:0] P0     = 32'h8000_0000;
    localparam logic [19:0] V1     = 20'h12345;
    localparam logic [19:0] V2     = 20'hFEDCB;
    localparam logic [19:0] VX     = 20'h0F0F0;
    localparam logic [31:0] PDE_OK = 32'h0010_0001;
    localparam logic [31:0] PTE_OK = 32'h000A_BCD5;
    localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

    // L1 entry address: base + 4 * upper ten VPN bits, modulo 2^32.
    function automatic logic [31:0] a1(input logic [19:0] v, input logic [31:0] p);
        logic [31:0] idx;
        idx = 32'(v) / 1024;
        return p + idx * 4;
    endfunction

    // L2 entry address: PDE frame (low 12 bits cleared) + 4 * lower ten VPN bits.
    function automatic logic [31:0] a2(input logic [31:0] pde, input logic [19:0] v);
        logic [31:0] idx;
        idx = 32'(v) % 1024;
        return (pde / 4096) * 4096 + idx * 4;
    endfunction

    function automatic vec_t mk(input logic lk, hit, kl, rdy, input logic [19:0] vp,
                                input logic [31:0] rd, input logic st, rq,
                                input logic [31:0] ad, input logic wr,
                                input logic [23:0] pt, input logic ft, cb,
                                input logic [19:0] eb);
        vec_t r;
        r.lk = lk; r.hit = hit; r.kl = kl; r.rdy = rdy; r.vp = vp; r.rd = rd;
        r.pb = cur_ptbr; r.st = st; r.rq = rq; r.ad = ad; r.wr = wr; r.pt = pt;
        r.ft = ft; r.cb = cb; r.eb = eb;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        lookup        = v.lk;
        tlb_hit       = v.hit;
        kill          = v.kl;
        vpn           = v.vp;
        ptbr          = v.pb;
        mif.mem_ready = v.rdy;
        mif.mem_rdata = v.rd;
        #1;
        check({tag, ".stall"}, 32'(stall), 32'(v.st));
        check({tag, ".mem_req"}, 32'(mif.mem_req), 32'(v.rq));
        if (v.rq) check({tag, ".mem_addr"}, mif.mem_addr, v.ad);
        check({tag, ".tlbwr"}, 32'(tlbwr), 32'(v.wr));
        if (v.wr) check({tag, ".pte_in"}, 32'(pte_in), 32'(v.pt));
        check({tag, ".page_fault"}, 32'(page_fault), 32'(v.ft));
        if (v.cb) check({tag, ".bad_vpn"}, 32'(bad_vpn), 32'(v.eb));
    endtask

    // Expected per-cycle timeline of one walk from the cycle after the miss.
    task automatic plan_walk(input logic [19:0] v, input logic [31:0] p);
        int unsigned w1, w2;
        logic [31:0] pde, pte;
        step_t s;
        w1  = $urandom_range(0, 3);
        w2  = $urandom_range(0, 3);
        pde = $urandom;
        pte = $urandom;
        pde[0] = ($urandom_range(0, 3) != 0);
        pte[0] = ($urandom_range(0, 4) != 0);
        s.wr = 1'b0; s.ft = 1'b0; s.pt = '0; s.fv = v;
        for (int unsigned i = 0; i <= w1; i++) begin
            s.rq = 1'b1; s.ad = a1(v, p); s.rdy = (i == w1);
            s.rd = (i == w1) ? pde : $urandom;
            script.push_back(s);
        end
        if (!pde[0]) begin
            s.rq = 1'b0; s.rdy = 1'b0; s.rd = $urandom; s.ft = 1'b1;
            script.push_back(s);
            return;
        end
        for (int unsigned i = 0; i <= w2; i++) begin
            s.rq = 1'b1; s.ad = a2(pde, v); s.rdy = (i == w2);
            s.rd = (i == w2) ? pte : $urandom;
            script.push_back(s);
        end
        s.rq = 1'b0; s.rdy = 1'b0; s.rd = $urandom;
        if (pte[0]) begin
            s.wr = 1'b1; s.pt = pte[23:0];
        end else begin
            s.ft = 1'b1;
        end
        script.push_back(s);
    endtask

    initial begin
        logic [19:0] exp_bad;
        clr = 1'b1; lookup = 1'b0; tlb_hit = 1'b0; kill = 1'b0;
        vpn = '0; ptbr = P0; cur_ptbr = P0;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset.mem_req", 32'(mif.mem_req), 32'd0);
        check("reset.mem_addr", mif.mem_addr, 32'd0);
        check("reset.stall", 32'(stall), 32'd0);
        check("reset.tlbwr", 32'(tlbwr), 32'd0);
        check("reset.pte_in", 32'(pte_in), 32'd0);
        check("reset.page_fault", 32'(page_fault), 32'd0);
        check("reset.bad_vpn", 32'(bad_vpn), 32'd0);
        clr = 1'b0;

        // zero-wait walk; a second miss with another vpn during the walk is ignored
        tbl.push_back(mk(1,0,0,0,V1,'0,     1,0,'0,             0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,1,VX,PDE_OK, 1,1,a1(V1,P0),      0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,1,VX,PTE_OK, 1,1,a2(PDE_OK,V1),  0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,VX,JUNK,   1,0,'0,             1,24'hABCD5,0,1,'0));
        tbl.push_back(mk(1,1,0,0,V1,'0,     0,0,'0,             0,'0,0,1,'0));
        // two wait cycles per read: tlbwr at cycle 7
        tbl.push_back(mk(1,0,0,0,V1,'0,     1,0,'0,             0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,V1,JUNK,   1,1,a1(V1,P0),      0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,V1,JUNK,   1,1,a1(V1,P0),      0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,1,V1,PDE_OK, 1,1,a1(V1,P0),      0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,V1,JUNK,   1,1,a2(PDE_OK,V1),  0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,V1,JUNK,   1,1,a2(PDE_OK,V1),  0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,1,V1,PTE_OK, 1,1,a2(PDE_OK,V1),  0,'0,0,1,'0));
        tbl.push_back(mk(1,0,0,0,V1,'0,     1,0,'0,             1,24'hABCD5,0,1,'0));
        tbl.push_back(mk(1,1,0,0,V1,'0,     0,0,'0,             0,'0,0,1,'0));
        // invalid PDE: fault at cycle 2
        tbl.push_back(mk(1,0,0,0,V2,'0,           1,0,'0,         0,'0,0,1,'0));
        tbl.push_back(mk(0,0,0,1,V2,32'h0010_0000,1,1,a1(V2,P0),  0,'0,0,1,'0));
        tbl.push_back(mk(0,0,0,0,V2,'0,           1,0,'0,         0,'0,1,0,'0));
        tbl.push_back(mk(0,0,0,0,V2,'0,           0,0,'0,         0,'0,0,1,V2));
        // kill in PTE with memory not ready for 3 cycles: drain
        tbl.push_back(mk(1,0,0,0,V1,'0,     1,0,'0,             0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,1,V1,PDE_OK, 1,1,a1(V1,P0),      0,'0,0,1,V2));
        tbl.push_back(mk(0,0,1,0,V1,JUNK,   1,1,a2(PDE_OK,V1),  0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,0,V1,JUNK,   1,1,a2(PDE_OK,V1),  0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,0,V1,JUNK,   1,1,a2(PDE_OK,V1),  0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,1,V1,PTE_OK, 1,1,a2(PDE_OK,V1),  0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,0,V1,'0,     0,0,'0,             0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,0,V1,'0,     0,0,'0,             0,'0,0,1,V2));
        // kill in PDE with ready in the same cycle: straight to idle
        tbl.push_back(mk(1,0,0,0,V1,'0,     1,0,'0,             0,'0,0,1,V2));
        tbl.push_back(mk(0,0,1,1,V1,PDE_OK, 1,1,a1(V1,P0),      0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,0,V1,'0,     0,0,'0,             0,'0,0,1,V2));
        // invalid PTE, kill during the fault cycle is ignored
        tbl.push_back(mk(1,0,0,0,V1,'0,           1,0,'0,            0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,1,V1,PDE_OK,       1,1,a1(V1,P0),     0,'0,0,1,V2));
        tbl.push_back(mk(0,0,0,1,V1,32'h000ABCD4, 1,1,a2(PDE_OK,V1), 0,'0,0,1,V2));
        tbl.push_back(mk(0,0,1,0,V1,'0,           1,0,'0,            0,'0,1,0,'0));
        tbl.push_back(mk(0,0,0,0,V1,'0,           0,0,'0,            0,'0,0,1,V1));
        // kill during the write cycle is ignored
        tbl.push_back(mk(1,0,0,0,V2,'0,     1,0,'0,             0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,1,V2,PDE_OK, 1,1,a1(V2,P0),      0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,1,V2,PTE_OK, 1,1,a2(PDE_OK,V2),  0,'0,0,1,V1));
        tbl.push_back(mk(0,0,1,0,V2,'0,     1,0,'0,             1,24'hABCD5,0,1,V1));
        tbl.push_back(mk(0,0,0,0,V2,'0,     0,0,'0,             0,'0,0,1,V1));
        // miss with kill in the same cycle never starts a walk
        tbl.push_back(mk(1,0,1,0,V2,'0,     0,0,'0,             0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,0,V2,'0,     0,0,'0,             0,'0,0,1,V1));
        // 32-bit wrap of the L1 address, top PTE byte dropped
        cur_ptbr = 32'hFFFF_FF00;
        tbl.push_back(mk(1,0,0,0,20'hFFFFF,'0,           1,0,'0,           0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,1,20'hFFFFF,32'hFFFF_F001,1,1,32'h0000_0EFC,0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,1,20'hFFFFF,32'hFF12_3457,1,1,32'hFFFF_FFFC,0,'0,0,1,V1));
        tbl.push_back(mk(0,0,0,0,20'hFFFFF,'0,           1,0,'0,           1,24'h123457,0,1,V1));
        tbl.push_back(mk(0,0,0,0,20'hFFFFF,'0,           0,0,'0,           0,'0,0,1,V1));
        cur_ptbr = P0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // asynchronous clear while the PDE read is outstanding
        apply(mk(1,0,0,0,V1,'0,   1,0,'0,        0,'0,0,1,V1), "clr.miss");
        apply(mk(0,0,0,0,V1,JUNK, 1,1,a1(V1,P0), 0,'0,0,1,V1), "clr.pde");
        clr = 1'b1;
        #1;
        check("clr.mem_req", 32'(mif.mem_req), 32'd0);
        check("clr.mem_addr", mif.mem_addr, 32'd0);
        check("clr.stall", 32'(stall), 32'd0);
        check("clr.tlbwr", 32'(tlbwr), 32'd0);
        check("clr.pte_in", 32'(pte_in), 32'd0);
        check("clr.page_fault", 32'(page_fault), 32'd0);
        check("clr.bad_vpn", 32'(bad_vpn), 32'd0);
        #1 clr = 1'b0;
        apply(mk(1,0,0,0,V2,'0,     1,0,'0,            0,'0,0,1,'0), "fresh.miss");
        apply(mk(0,0,0,1,V2,PDE_OK, 1,1,a1(V2,P0),     0,'0,0,1,'0), "fresh.pde");
        apply(mk(0,0,0,1,V2,PTE_OK, 1,1,a2(PDE_OK,V2), 0,'0,0,1,'0), "fresh.pte");
        apply(mk(0,0,0,0,V2,'0,     1,0,'0,            1,24'hABCD5,0,1,'0), "fresh.wr");
        apply(mk(1,1,0,0,V2,'0,     0,0,'0,            0,'0,0,1,'0), "fresh.idle");

        // randomized traffic against the walk timeline model
        exp_bad = '0;
        for (int n = 0; n < 4000; n++) begin
            vec_t  v;
            step_t s;
            if (script.size() == 0) begin
                if ($urandom_range(0, 7) == 0) cur_ptbr = $urandom;
                v = mk($urandom_range(0,1), $urandom_range(0,1), ($urandom_range(0,7) == 0), 1'b0,
                       20'($urandom), $urandom, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1, exp_bad);
                v.st = v.lk & ~v.hit & ~v.kl;
                if (v.st) plan_walk(v.vp, cur_ptbr);
                apply(v, "rnd.idle");
            end else begin
                s = script.pop_front();
                v = mk($urandom_range(0,1), $urandom_range(0,1),
                       (s.wr | s.ft) ? 1'($urandom_range(0,1)) : 1'b0, s.rdy,
                       20'($urandom), s.rd, 1'b1, s.rq, s.ad, s.wr, s.pt, s.ft, !s.ft, exp_bad);
                apply(v, "rnd.walk");
                if (s.ft) exp_bad = s.fv;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
